// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - shared types, bus addresses and helpers for the SPART echo driver
package spart_pkg;

  typedef enum logic [2:0] {CFG_LO, CFG_HI, IDLE, RD, WR, HOLD} state_t;

  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DBL    = 2'b10;
  localparam logic [1:0] ADDR_DBH    = 2'b11;

  function automatic logic [15:0] baud_div(input int unsigned clk_hz, input int unsigned baud);
    int unsigned q;
    q = clk_hz / baud;
    return q[15:0];
  endfunction

  function automatic logic [7:0] ascii_upcase(input logic [7:0] b);
    if (b >= 8'h61 && b <= 8'h7a) return b - 8'h20;
    return b;
  endfunction

endpackage

// File: rtl/spart_echo_driver_if.sv
// rtl/spart_echo_driver_if.sv - SPART control/handshake signals between driver and core
interface spart_echo_driver_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (output iocs, iorw, ioaddr, input rda, tbr);
  modport slave  (input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_byte_fifo.sv
// rtl/spart_byte_fifo.sv - byte FIFO buffering received characters until the transmitter is free
module spart_byte_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage is left unreset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop_ok)      count <= count + (AW+1)'(1);
      else if (pop_ok && !push_ok) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/spart_echo_driver.sv
// rtl/spart_echo_driver.sv - programs the SPART divisor, then echoes received bytes through a FIFO
module spart_echo_driver
  import spart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD0      = 4800,
  parameter int unsigned BAUD1      = 9600,
  parameter int unsigned BAUD2      = 19200,
  parameter int unsigned BAUD3      = 38400,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   br_cfg,
  input  logic                         upcase,
  spart_echo_driver_if.master          bus,
  inout  wire  [7:0]                   databus,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow
);

  localparam logic [15:0] DIV0 = baud_div(CLK_HZ, BAUD0);
  localparam logic [15:0] DIV1 = baud_div(CLK_HZ, BAUD1);
  localparam logic [15:0] DIV2 = baud_div(CLK_HZ, BAUD2);
  localparam logic [15:0] DIV3 = baud_div(CLK_HZ, BAUD3);

  function automatic logic [15:0] div_of(input logic [1:0] sel);
    case (sel)
      2'b00:   return DIV0;
      2'b01:   return DIV1;
      2'b10:   return DIV2;
      default: return DIV3;
    endcase
  endfunction

  state_t      state, state_n;
  logic [1:0]  br_cfg_q;
  logic        drive_en;
  logic [7:0]  data_out;
  logic [15:0] div_lo_src;
  logic [15:0] div_hi_src;
  logic        fifo_full, fifo_empty;
  logic [7:0]  fifo_head;
  logic        push, pop;

  // Low byte follows the live select because br_cfg_q is only latched at the end of CFG_LO.
  assign div_lo_src = div_of(br_cfg);
  assign div_hi_src = div_of(br_cfg_q);
  assign databus    = drive_en ? data_out : 8'hzz;
  assign push       = (state == RD);
  assign pop        = (state == WR);

  spart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (databus),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CFG_LO;
      br_cfg_q <= br_cfg;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      if (state == CFG_LO)           br_cfg_q <= br_cfg;
      if (state == RD && fifo_full)  overflow <= 1'b1;
    end
  end

  always_comb begin
    state_n    = state;
    bus.iocs   = 1'b0;
    bus.iorw   = 1'b0;
    bus.ioaddr = ADDR_DATA;
    drive_en   = 1'b0;
    data_out   = 8'h00;
    case (state)
      CFG_LO: begin
        bus.iocs   = 1'b1;
        bus.ioaddr = ADDR_DBL;
        drive_en   = 1'b1;
        data_out   = div_lo_src[7:0];
        state_n    = CFG_HI;
      end
      CFG_HI: begin
        bus.iocs   = 1'b1;
        bus.ioaddr = ADDR_DBH;
        drive_en   = 1'b1;
        data_out   = div_hi_src[15:8];
        state_n    = IDLE;
      end
      IDLE: begin
        if (br_cfg != br_cfg_q)           state_n = CFG_LO;
        else if (bus.rda)                 state_n = RD;
        else if (bus.tbr && !fifo_empty)  state_n = WR;
      end
      RD: begin
        bus.iocs = 1'b1;
        bus.iorw = 1'b1;
        state_n  = IDLE;
      end
      WR: begin
        bus.iocs = 1'b1;
        drive_en = 1'b1;
        data_out = upcase ? ascii_upcase(fifo_head) : fifo_head;
        state_n  = HOLD;
      end
      HOLD: state_n = IDLE;
      default: state_n = CFG_LO;
    endcase
  end

endmodule

// File: tb/tb_spart_echo_driver.sv
// tb/tb_spart_echo_driver.sv - directed vectors and corner sequences for spart_echo_driver
module tb_spart_echo_driver;

  logic       clk;
  logic       rst_n;
  logic [1:0] br_cfg;
  logic       upcase;
  logic [7:0] spart_data;
  logic [3:0] fifo_count;
  logic       overflow;
  wire  [7:0] databus;

  int total;
  int bad;
  logic [7:0] tx_q[$];

  spart_echo_driver_if bus();

  spart_echo_driver dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .br_cfg     (br_cfg),
    .upcase     (upcase),
    .bus        (bus),
    .databus    (databus),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  assign databus = (bus.iocs && bus.iorw) ? spart_data : 8'hzz;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (bus.iocs && !bus.iorw && bus.ioaddr == 2'b00) tx_q.push_back(databus);
  end

  typedef struct {
    logic       up;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Starts and ends at a negedge with the DUT in IDLE.
  task automatic rx_byte(input logic [7:0] b);
    bus.rda    = 1'b1;
    spart_data = b;
    @(negedge clk);
    bus.rda = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'h41, 8'h41};
    vecs[1] = '{1'b1, 8'h61, 8'h41};
    vecs[2] = '{1'b1, 8'h7b, 8'h7b};
    vecs[3] = '{1'b1, 8'h7a, 8'h5a};
    vecs[4] = '{1'b1, 8'h60, 8'h60};
    vecs[5] = '{1'b0, 8'h61, 8'h61};
    vecs[6] = '{1'b1, 8'h00, 8'h00};

    total = 0;
    bad = 0;
    rst_n = 1'b0;
    br_cfg = 2'b01;
    upcase = 1'b0;
    spart_data = 8'h00;
    bus.rda = 1'b0;
    bus.tbr = 1'b0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("cfg_lo_iocs", 16'(bus.iocs), 16'h1);
    chk("cfg_lo_iorw", 16'(bus.iorw), 16'h0);
    chk("cfg_lo_addr", 16'(bus.ioaddr), 16'h2);
    chk("cfg_lo_data", 16'(databus), 16'h58);
    @(negedge clk);
    chk("cfg_hi_addr", 16'(bus.ioaddr), 16'h3);
    chk("cfg_hi_data", 16'(databus), 16'h14);
    @(negedge clk);
    chk("idle_iocs", 16'(bus.iocs), 16'h0);
    chk("rst_count", 16'(fifo_count), 16'h0);
    chk("rst_ovf", 16'(overflow), 16'h0);

    bus.tbr = 1'b1;
    for (int i = 0; i < 7; i++) begin
      upcase = vecs[i].up;
      bus.rda = 1'b1;
      spart_data = vecs[i].din;
      @(negedge clk);
      chk("rd_iocs", 16'(bus.iocs), 16'h1);
      chk("rd_iorw", 16'(bus.iorw), 16'h1);
      chk("rd_addr", 16'(bus.ioaddr), 16'h0);
      bus.rda = 1'b0;
      @(negedge clk);
      chk("echo_idle_iocs", 16'(bus.iocs), 16'h0);
      chk("echo_count1", 16'(fifo_count), 16'h1);
      @(negedge clk);
      chk("wr_iocs_iorw", {8'(bus.iocs), 8'(bus.iorw)}, 16'h0100);
      chk("wr_addr", 16'(bus.ioaddr), 16'h0);
      chk("wr_data", 16'(databus), 16'(vecs[i].exp));
      @(negedge clk);
      chk("hold_iocs", 16'(bus.iocs), 16'h0);
      chk("hold_count0", 16'(fifo_count), 16'h0);
      @(negedge clk);
    end

    // Fill past capacity with the transmitter busy.
    upcase = 1'b0;
    bus.tbr = 1'b0;
    for (int i = 0; i < 9; i++) rx_byte(8'(i));
    chk("full_count", 16'(fifo_count), 16'h8);
    chk("full_ovf", 16'(overflow), 16'h1);
    tx_q.delete();
    bus.tbr = 1'b1;
    repeat (40) @(negedge clk);
    chk("drain_size", 16'(tx_q.size()), 16'h8);
    for (int i = 0; i < 8 && i < tx_q.size(); i++) chk("drain_byte", 16'(tx_q[i]), 16'(i));
    chk("drain_count", 16'(fifo_count), 16'h0);
    chk("ovf_sticky", 16'(overflow), 16'h1);

    // Reconfigure with bytes held in the FIFO.
    bus.tbr = 1'b0;
    rx_byte(8'h10);
    rx_byte(8'h11);
    rx_byte(8'h12);
    br_cfg = 2'b11;
    @(negedge clk);
    chk("recfg_lo_iocs", 16'(bus.iocs), 16'h1);
    chk("recfg_lo_addr", 16'(bus.ioaddr), 16'h2);
    chk("recfg_lo_data", 16'(databus), 16'h16);
    chk("recfg_count", 16'(fifo_count), 16'h3);
    @(negedge clk);
    chk("recfg_hi_addr", 16'(bus.ioaddr), 16'h3);
    chk("recfg_hi_data", 16'(databus), 16'h05);
    @(negedge clk);
    chk("recfg_idle", 16'(bus.iocs), 16'h0);
    chk("recfg_count_kept", 16'(fifo_count), 16'h3);
    tx_q.delete();
    bus.tbr = 1'b1;
    repeat (15) @(negedge clk);
    chk("recfg_tx_size", 16'(tx_q.size()), 16'h3);
    for (int i = 0; i < 3 && i < tx_q.size(); i++) chk("recfg_tx_byte", 16'(tx_q[i]), 16'(8'h10 + i));

    // Read beats write in IDLE; then reset lands in the middle of WR.
    bus.tbr = 1'b0;
    rx_byte(8'h20);
    bus.rda = 1'b1;
    bus.tbr = 1'b1;
    spart_data = 8'h21;
    @(negedge clk);
    chk("prio_rd", {8'(bus.iocs), 8'(bus.iorw)}, 16'h0101);
    bus.rda = 1'b0;
    @(negedge clk);
    chk("prio_count", 16'(fifo_count), 16'h2);
    @(negedge clk);
    chk("prio_wr_iorw", 16'(bus.iorw), 16'h0);
    chk("prio_wr_data", 16'(databus), 16'h20);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_wr_iocs", 16'(bus.iocs), 16'h1);
    chk("rst_wr_addr", 16'(bus.ioaddr), 16'h2);
    chk("rst_wr_data", 16'(databus), 16'h16);
    chk("rst_wr_count", 16'(fifo_count), 16'h0);
    chk("rst_wr_ovf", 16'(overflow), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spart_echo_driver.md
Name: spart_echo_driver

Overview:
- Parametrised successor to the SPART bring-up driver: programs the SPART baud divisor from a parameterised clock/baud table, then runs a buffered echo loop.
- Received bytes are read into an internal FIFO and written back to the SPART transmitter when it is ready.
- Adds re-programming on `br_cfg` change, an optional uppercase transform, and overflow reporting.
- Sits between the board switches and the SPART core on the same `iocs`/`iorw`/`ioaddr`/`databus` bus.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- BAUD0, 4800, baud rate selected by br_cfg=00.
- BAUD1, 9600, baud rate selected by br_cfg=01.
- BAUD2, 19200, baud rate selected by br_cfg=10.
- BAUD3, 38400, baud rate selected by br_cfg=11.
- FIFO_DEPTH, 8, echo buffer depth; power of 2, at least 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low; clock clk.
- br_cfg  in  2  baud select, sampled every cycle.
- upcase  in  1  when 1, ASCII 'a'..'z' is converted to 'A'..'Z' at transmit time.
- rda  in  1  SPART receive data available.
- tbr  in  1  SPART transmit buffer ready.
- iocs  out  1  bus chip select; one cycle per access.
- iorw  out  1  1 = read from SPART, 0 = write to SPART.
- ioaddr  out  2  00 data, 01 status (unused), 10 divisor low, 11 divisor high.
- databus  inout  8  driven only when iocs=1 and iorw=0, otherwise high-Z.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky; set when a received byte is dropped.

Behaviour:
- Divisor: div = CLK_HZ/BAUDn (integer floor), 16 bits. Example: 50 MHz with 9600 baud gives 5208 = 0x1458.
- Reset values: state=CFG_LO, iocs=0, iorw=0, ioaddr=00, databus=Z, fifo_count=0, overflow=0, FIFO pointers=0, br_cfg_q=br_cfg.
- States: CFG_LO, CFG_HI, IDLE, RD, WR, HOLD. Outputs are combinational from the state.
- CFG_LO: iocs=1, iorw=0, ioaddr=10, databus=div[7:0]; latch br_cfg_q<=br_cfg; go to CFG_HI.
- CFG_HI: iocs=1, iorw=0, ioaddr=11, databus=div[15:8] (div computed from br_cfg_q); go to IDLE.
- IDLE: iocs=0. Transition priority:
  - br_cfg != br_cfg_q: go to CFG_LO.
  - else rda: go to RD.
  - else tbr and FIFO not empty: go to WR.
  - else stay in IDLE.
- RD: iocs=1, iorw=1, ioaddr=00.
  - databus is sampled at the closing posedge and pushed to the FIFO; go to IDLE.
  - If the FIFO is full, the byte is read (clearing the SPART) but discarded, and overflow<=1.
- WR: iocs=1, iorw=0, ioaddr=00, databus=xform(FIFO head); pop at the closing posedge; go to HOLD.
- HOLD: iocs=0 for one cycle, giving tbr time to fall so no double write occurs; go to IDLE.
- xform: if upcase=1 and the byte is in 0x61..0x7A, subtract 0x20; otherwise pass through. The upcase value at WR time applies.
- Latencies:
  - Reset release to first CFG_LO access: 0 cycles (CFG_LO is active in the first cycle).
  - Configuration completes in 2 cycles.
  - Minimum rda-to-transmit latency, with tbr=1 and FIFO empty: RD, IDLE, WR, i.e. the write occurs 2 cycles after RD.
- FIFO: pointers wrap modulo FIFO_DEPTH. Push and pop never occur in the same cycle because RD and WR are exclusive states.
- Reconfiguration: FIFO contents and overflow are preserved. A br_cfg change during RD/WR/HOLD is serviced at the next IDLE. A change during CFG_LO is taken, and one during CFG_HI is re-detected at IDLE.
- overflow clears only on reset.
- Reset mid-operation (any state): all state above returns to reset values, FIFO data is discarded, and the divisor is reprogrammed.

Decomposition:
- Package spart_pkg contains:
  - state_t enum.
  - ioaddr constants ADDR_DATA, ADDR_STATUS, ADDR_DBL, ADDR_DBH.
  - Function baud_div(clk_hz, baud) returning logic [15:0].
  - Function ascii_upcase(byte).
- Sub-module spart_byte_fifo, parameterised on DEPTH and 8-bit width, with ports push, pop, din, dout, full, empty, count, synchronous reset.

Test Plan:
- Reset with br_cfg=01 -> cycle 0 writes ioaddr=10 data 0x58, cycle 1 writes ioaddr=11 data 0x14, then IDLE with iocs=0.
- rda=1 with the SPART driving 0x41, tbr=1 -> one RD cycle, then WR with databus=0x41 two cycles later, then HOLD; fifo_count goes 0->1->0.
- upcase=1, receive 0x61 then 0x7B -> transmitted 0x41 then 0x7B.
- tbr=0, 9 received bytes 0x00..0x08, DEPTH=8 -> fifo_count=8, overflow=1; then tbr=1 -> writes 0x00..0x07 in order, 0x08 never sent.
- 3 bytes buffered with tbr=0, then br_cfg 01->11 -> writes ioaddr=10 data 0x16 and ioaddr=11 data 0x05 (1302); fifo_count stays 3 and bytes echo afterwards.
- rda=1 and tbr=1 with the FIFO non-empty in IDLE -> RD taken first; rst_n=0 during WR -> next cycle is CFG_LO, fifo_count=0, overflow=0.
